sram_mem_ctrl: RTL
==================

Name: sram_mem_ctrl

Overview:
- Multi-cycle data-memory controller that replaces the single-cycle data memory behind the MEM stage.
- Takes the MEM-stage request: `mem_r_en`/`mem_w_en`, the ALU-computed byte address and the store value.
- Serialises each 32-bit access into two 16-bit transactions on an external SRAM port.
- Drives `ready` low while busy so the hazard/freeze logic stalls every pipeline register until the word is returned or written.

Parameters:
- ADDR_BASE, 1024: byte address subtracted from `alu_result` before mapping to SRAM.
- SRAM_AW, 18: SRAM half-word address width.
- PHASE_CYCLES, 2: cycles each 16-bit half-access occupies; legal range 2..15.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- mem_r_en  in  1  load request, held stable while `ready`=0
- mem_w_en  in  1  store request, held stable while `ready`=0
- alu_result  in  32  byte address
- ST_value  in  32  store data
- memory_result  out  32  load data, registered
- ready  out  1  1 = pipeline may advance this cycle
- sram_addr  out  SRAM_AW  half-word address
- sram_dq_o  out  16  write data to SRAM
- sram_dq_i  in  16  read data from SRAM
- sram_dq_oe  out  1  1 = controller drives the data bus
- sram_we_n  out  1  active-low SRAM write strobe

Behaviour:
- Address mapping:
  - offs = alu_result - ADDR_BASE, 32-bit modulo.
  - word = offs[SRAM_AW:2]; bits above are discarded (wrap), offs[1:0] ignored.
  - Low half at half-word address {word,0}, high half at {word,1}.
- States: IDLE, LO, HI, DONE. A 4-bit phase counter runs 0..PHASE_CYCLES-1 in LO and HI.
- IDLE:
  - If mem_w_en or mem_r_en: latch op (write wins if both), latch address and ST_value, go to LO with cnt=0.
  - Otherwise stay in IDLE.
- LO/HI:
  - cnt increments each cycle. At cnt=PHASE_CYCLES-1, LO goes to HI (cnt cleared) and HI goes to DONE.
- DONE: lasts exactly one cycle, then IDLE. Inputs are ignored in DONE; the pipeline advances on that edge.
- ready (combinational):
  - 1 in IDLE with no request, and in DONE.
  - 0 otherwise, including the IDLE cycle in which a request is first seen.
- Latency: request first seen in cycle 0; ready=1 in cycle 2*PHASE_CYCLES+1. With PHASE_CYCLES=2, ready=1 in cycle 5.
- sram_addr: {word,0} in LO, {word,1} in HI, 0 in IDLE/DONE.
- Writes:
  - sram_dq_oe=1 for all of LO/HI.
  - sram_dq_o = ST_value[15:0] in LO, ST_value[31:16] in HI.
  - sram_we_n=0 for cnt>=1 of each phase. It is high on cnt=0 so the address settles first.
- Reads:
  - sram_dq_oe=0 and sram_we_n=1 throughout.
  - sram_dq_i is sampled at cnt=PHASE_CYCLES-1: into bits 15:0 in LO, 31:16 in HI.
  - memory_result updates only at the end of HI of a read, so it is valid in DONE. It then holds until the next read completes; writes never alter it.
- Reset values (asynchronous, reset=0): state=IDLE, cnt=0, memory_result=0, sram_addr=0, sram_dq_o=0, sram_dq_oe=0, sram_we_n=1.
- Reset mid-transaction aborts immediately; the half-written word is left undefined in SRAM.
- Back-to-back requests: a request present in IDLE after DONE starts a new transaction. There are no idle bubbles beyond the DONE→IDLE cycle.

Decomposition:
- Shared pipeline package holds:
  - state enum {IDLE, LO, HI, DONE}
  - ADDR_BASE default constant
  - SRAM_DW=16
- No sub-module is needed. The address mapping is reused from the existing address-mapping function; the FSM, datapath and output registers live in one module.

Test Plan:
- Reset asserted mid-HI of a write -> all outputs return to reset values in the same cycle; state=IDLE; ready=1 once reset deasserts with no request.
- Store alu_result=1028, ST_value=0xDEADBEEF, PHASE_CYCLES=2:
  - cycles 1-2: sram_addr=2, dq_o=0xBEEF, we_n low in cycle 2 only.
  - cycles 3-4: sram_addr=3, dq_o=0xDEAD, we_n low in cycle 4 only.
  - ready=1 in cycle 5.
- Load from 1028 with SRAM model returning the stored halves -> memory_result=0xDEADBEEF in cycle 5; ready low in cycles 0-4.
- mem_r_en=mem_w_en=1 at 1032 -> write performed (we_n pulses at sram_addr 4 and 5); memory_result unchanged.
- Address wrap: alu_result=1024+(1<<20)+8 with SRAM_AW=18 -> sram_addr=4 then 5.
- Load immediately followed by store, requests held through ready -> second transaction's LO starts one cycle after DONE; each transaction has ready=1 for exactly one cycle.

Source files
------------

// File: rtl/sram_mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM data-memory controller:
// FSM state encoding, default address base, SRAM data width and the
// byte-address to SRAM word-index mapping.
package sram_mem_ctrl_pkg;

    // Controller FSM states: wait for a request, low half, high half, handoff.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Byte address at which the data memory window starts.
    localparam int ADDR_BASE_DEFAULT = 1024;

    // External SRAM data bus width (one half of a 32-bit word).
    localparam int SRAM_DW = 16;

    // Width of the per-phase cycle counter (enough for PHASE_CYCLES up to 15).
    localparam int CNT_W = 4;

    // Byte address -> 32-bit word index relative to the window base.
    // Subtraction is modulo 2^32; the two byte-offset bits are dropped.
    // Callers truncate the result to the SRAM word-index width, which
    // gives the wrap-around behaviour for addresses beyond the SRAM.
    function automatic logic [31:0] map_word(input logic [31:0] byte_addr,
                                             input logic [31:0] base);
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_mem_ctrl.sv
// Multi-cycle data memory controller for the MEM stage.
// Each 32-bit load/store is split into two 16-bit SRAM accesses (low half
// at the even half-word address, high half at the odd one). While an
// access is in flight, ready is held low so the pipeline freezes; ready
// rises for exactly one cycle (DONE) when the word has been moved.
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter int ADDR_BASE    = ADDR_BASE_DEFAULT,
    parameter int SRAM_AW      = 18,
    parameter int PHASE_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_r_en,
    input  logic                  mem_w_en,
    input  logic [31:0]           alu_result,
    input  logic [31:0]           ST_value,
    output logic [31:0]           memory_result,
    output logic                  ready,
    output logic [SRAM_AW-1:0]    sram_addr,
    output logic [SRAM_DW-1:0]    sram_dq_o,
    input  logic [SRAM_DW-1:0]    sram_dq_i,
    output logic                  sram_dq_oe,
    output logic                  sram_we_n
);

    // Last value of the phase counter; each half-access spans 0..LAST.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PHASE_CYCLES - 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   is_write;      // latched operation: 1 = store
    logic [SRAM_AW-2:0]     addr_word;     // latched SRAM word index
    logic [SRAM_DW-1:0]     st_hi;         // latched upper half of store data
    logic [SRAM_DW-1:0]     rd_lo;         // low half captured during a load
    logic [SRAM_AW-2:0]     word_in;       // word index of the incoming request
    logic                   req;

    // Word index of the current request; upper bits wrap by truncation.
    assign word_in = (SRAM_AW-1)'(map_word(alu_result, 32'(ADDR_BASE)));
    assign req     = mem_r_en | mem_w_en;

    // Pipeline may advance when idle with nothing to do, or on the handoff cycle.
    always_comb begin
        ready = 1'b0;
        if (state == DONE) begin
            ready = 1'b1;
        end else if (state == IDLE && !req) begin
            ready = 1'b1;
        end
    end

    // FSM, datapath latches and registered SRAM pins, all updated together
    // so every SRAM output is glitch-free and aligned with the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            is_write      <= 1'b0;
            addr_word     <= '0;
            st_hi         <= '0;
            rd_lo         <= '0;
            memory_result <= '0;
            sram_addr     <= '0;
            sram_dq_o     <= '0;
            sram_dq_oe    <= 1'b0;
            sram_we_n     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // Store wins when both enables are set.
                        state      <= LO;
                        cnt        <= '0;
                        is_write   <= mem_w_en;
                        addr_word  <= word_in;
                        st_hi      <= ST_value[31:16];
                        sram_addr  <= {word_in, 1'b0};
                        sram_dq_o  <= mem_w_en ? ST_value[15:0] : '0;
                        sram_dq_oe <= mem_w_en;
                        // Strobe stays high on cnt=0 so the address settles first.
                        sram_we_n  <= 1'b1;
                    end
                end

                LO: begin
                    if (cnt == LAST) begin
                        state      <= HI;
                        cnt        <= '0;
                        if (!is_write) begin
                            rd_lo <= sram_dq_i;
                        end
                        sram_addr  <= {addr_word, 1'b1};
                        sram_dq_o  <= is_write ? st_hi : '0;
                        sram_we_n  <= 1'b1;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        sram_we_n  <= ~is_write;
                    end
                end

                HI: begin
                    if (cnt == LAST) begin
                        state      <= DONE;
                        cnt        <= '0;
                        // Load data becomes visible in DONE; stores leave it alone.
                        if (!is_write) begin
                            memory_result <= {sram_dq_i, rd_lo};
                        end
                        sram_addr  <= '0;
                        sram_dq_o  <= '0;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        sram_we_n  <= ~is_write;
                    end
                end

                DONE: begin
                    // Inputs are ignored here; the pipeline advances on this edge.
                    state <= IDLE;
                end

                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    sram_addr  <= '0;
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule
